joy_db15_responder: RTL and testbench

//  Device-side model of the DB15 UserIO joystick adapter, i.e. the two cascaded

---
 rtl/joy_db15_if.sv | 19 +
 rtl/joy_db15_responder.sv | 153 +++++++++++++++
 tb/tb_joy_db15_responder.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/joy_db15_if.sv
// DB15 UserIO serial link between the reader and the adapter.
// Reader drives clock and load; the adapter returns serial data.
interface joy_db15_if;
  logic joy_clk;
  logic joy_load;
  logic joy_data;

  modport master (
    output joy_clk,
    output joy_load,
    input  joy_data
  );

  modport slave (
    input  joy_clk,
    input  joy_load,
    output joy_data
  );
endinterface

// File: rtl/joy_db15_responder.sv
// Device-side model of the DB15 adapter shift-register chain.
// Latches both player words on load, shifts them out LSB-first.
module joy_db15_responder #(
  parameter int          WORD_BITS = 16,
  parameter logic [23:0] TIMEOUT   = 24'd4800000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  joy_db15_if.slave            joy,
  input  logic [WORD_BITS-1:0] joystick1,
  input  logic [WORD_BITS-1:0] joystick2,
  output logic                 frame_done,
  output logic [5:0]           bit_cnt,
  output logic                 link_active
);

  localparam int          FB  = 2 * WORD_BITS;
  localparam logic [5:0]  FB6 = 6'(FB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t        r_st;
  state_t        w_nxt;
  logic [2:0]    r_ck;
  logic [2:0]    r_ld;
  logic [FB-1:0] r_sreg;
  logic [FB-1:0] w_sreg_n;
  logic [FB-1:0] w_frame;
  logic [5:0]    r_cnt;
  logic [5:0]    w_cnt_n;
  logic [5:0]    w_cnt_inc;
  logic          r_done;
  logic          w_done_n;
  logic          r_data;
  logic [23:0]   r_wd;
  logic          r_link;
  logic          w_ck_rise;
  logic          w_ld_s;
  logic          w_ld_fall;
  logic          w_to;

  assign w_ck_rise = r_ck[1] & ~r_ck[2];
  assign w_ld_s    = r_ld[1];
  assign w_ld_fall = ~r_ld[1] & r_ld[2];
  assign w_frame   = ~{joystick2, joystick1};
  assign w_cnt_inc = r_cnt + 6'd1;
  assign w_to      = ~w_ld_fall
                   & (r_wd == TIMEOUT - 24'd1);

  assign joy.joy_data = r_data;
  assign frame_done   = r_done;
  assign bit_cnt      = r_cnt;
  assign link_active  = r_link;

  // Two-flop synchronisers plus a third stage for edge detect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ck <= 3'b111;
      r_ld <= 3'b111;
    end else begin
      r_ck <= {r_ck[1:0], joy.joy_clk};
      r_ld <= {r_ld[1:0], joy.joy_load};
    end
  end

  // Link watchdog: restarted by every load, drops link when it expires
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd   <= '0;
      r_link <= 1'b0;
    end else if (w_ld_fall) begin
      r_wd   <= '0;
      r_link <= 1'b1;
    end else begin
      if (r_wd != TIMEOUT)
        r_wd <= r_wd + 24'd1;
      if (w_to)
        r_link <= 1'b0;
    end
  end

  // State, shift register and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_st   <= S_IDLE;
      r_sreg <= '1;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_st   <= w_nxt;
      r_sreg <= w_sreg_n;
      r_cnt  <= w_cnt_n;
      r_done <= w_done_n;
    end
  end

  // Next-state logic; a low load always takes priority over shifting
  always_comb begin
    w_nxt    = r_st;
    w_sreg_n = r_sreg;
    w_cnt_n  = r_cnt;
    w_done_n = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        if (!w_ld_s)
          w_nxt = S_LOAD;
      end
      S_LOAD: begin
        if (w_ld_s) begin
          w_nxt = S_SHIFT;
        end else begin
          w_sreg_n = w_frame;
          w_cnt_n  = '0;
        end
      end
      S_SHIFT: begin
        if (!w_ld_s) begin
          w_nxt = S_LOAD;
        end else if (w_ck_rise) begin
          w_sreg_n = {1'b1, r_sreg[FB-1:1]};
          w_cnt_n  = w_cnt_inc;
          if (w_cnt_inc == FB6) begin
            w_done_n = 1'b1;
            w_nxt    = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (!w_ld_s)
          w_nxt = S_LOAD;
      end
      default: w_nxt = S_IDLE;
    endcase
    if (w_to)
      w_nxt = S_IDLE;
  end

  // Serial output: idle-high outside LOAD/SHIFT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_data <= 1'b1;
    else if (r_st == S_LOAD || r_st == S_SHIFT)
      r_data <= r_sreg[0];
    else
      r_data <= 1'b1;
  end

endmodule

// File: tb/tb_joy_db15_responder.sv
// Directed bench for joy_db15_responder.
// Drives the link as a reader would and checks returned frames.
module tb_joy_db15_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] j1;
  logic [15:0] j2;
  logic        frame_done;
  logic [5:0]  bit_cnt;
  logic        link_active;
  int          checks = 0;
  int          errors = 0;
  int          n_done = 0;

  joy_db15_if bus();

  joy_db15_responder #(
    .WORD_BITS (16),
    .TIMEOUT   (24'd1000)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .joy         (bus),
    .joystick1   (j1),
    .joystick2   (j2),
    .frame_done  (frame_done),
    .bit_cnt     (bit_cnt),
    .link_active (link_active)
  );

  always #10 clk = ~clk;

  always @(posedge clk)
    if (frame_done) n_done <= n_done + 1;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_load();
    bus.joy_load = 1'b0;
    cyc(6);
    bus.joy_load = 1'b1;
    cyc(6);
  endtask

  task automatic rd_bits(input int n,
                         output logic [63:0] w);
    w = '1;
    for (int i = 0; i < n; i++) begin
      w[i] = bus.joy_data;
      bus.joy_clk = 1'b1;
      cyc(6);
      bus.joy_clk = 1'b0;
      cyc(6);
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    bus.joy_clk  = 1'b0;
    bus.joy_load = 1'b1;
    j1 = '0;
    j2 = '0;
    cyc(3);
    checks++;
    if ({bus.joy_data, frame_done, bit_cnt, link_active}
        !== {1'b1, 1'b0, 6'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset: data=%b done=%b cnt=%0d link=%b",
               bus.joy_data, frame_done, bit_cnt, link_active);
    end
    reset_n = 1'b1;
    cyc(3);
  endtask

  task automatic test_single_bit();
    logic [63:0] w;
    int d0;
    j1 = 16'h0001;
    j2 = 16'h0000;
    d0 = n_done;
    do_load();
    rd_bits(32, w);
    checks++;
    if (w[31:0] !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL single_frame: got %h exp fffffffe", w[31:0]);
    end
    checks++;
    if (n_done - d0 != 1) begin
      errors++;
      $display("FAIL single_done: got %0d pulses exp 1", n_done - d0);
    end
    checks++;
    if (bit_cnt !== 6'd32) begin
      errors++;
      $display("FAIL single_cnt: got %0d exp 32", bit_cnt);
    end
  endtask

  task automatic test_pattern();
    logic [63:0] w;
    logic [63:0] x;
    int d0;
    j1 = 16'hA5A5;
    j2 = 16'h3C3C;
    d0 = n_done;
    do_load();
    rd_bits(32, w);
    checks++;
    if (w[31:0] !== 32'hC3C3_5A5A) begin
      errors++;
      $display("FAIL pattern_frame: got %h exp c3c35a5a", w[31:0]);
    end
    rd_bits(8, x);
    x[8] = bus.joy_data;
    checks++;
    if (x[8:0] !== 9'h1FF) begin
      errors++;
      $display("FAIL overrun_data: got %b exp all 1", x[8:0]);
    end
    checks++;
    if (bit_cnt !== 6'd32 || n_done - d0 != 1) begin
      errors++;
      $display("FAIL overrun_cnt: cnt=%0d pulses=%0d exp 32/1",
               bit_cnt, n_done - d0);
    end
  endtask

  task automatic test_input_change();
    logic [63:0] a;
    logic [63:0] b;
    logic [31:0] f;
    j1 = 16'h0000;
    j2 = 16'h1234;
    do_load();
    rd_bits(5, a);
    j1 = 16'hFFFF;
    rd_bits(27, b);
    f = {b[26:0], a[4:0]};
    checks++;
    if (f !== 32'hEDCB_FFFF) begin
      errors++;
      $display("FAIL change_old: got %h exp edcbffff", f);
    end
    do_load();
    rd_bits(32, a);
    checks++;
    if (a[31:0] !== 32'hEDCB_0000) begin
      errors++;
      $display("FAIL change_new: got %h exp edcb0000", a[31:0]);
    end
  endtask

  task automatic test_abort();
    logic [63:0] w;
    int d0;
    j1 = 16'h0003;
    j2 = 16'h8001;
    d0 = n_done;
    do_load();
    rd_bits(10, w);
    checks++;
    if (bit_cnt !== 6'd10 || bus.joy_data !== 1'b1) begin
      errors++;
      $display("FAIL abort_mid: cnt=%0d data=%b exp 10/1",
               bit_cnt, bus.joy_data);
    end
    bus.joy_load = 1'b0;
    cyc(6);
    bus.joy_clk = 1'b1;
    cyc(6);
    bus.joy_clk = 1'b0;
    cyc(6);
    checks++;
    if (bit_cnt !== 6'd0 || bus.joy_data !== 1'b0
        || n_done != d0) begin
      errors++;
      $display("FAIL abort_load: cnt=%0d data=%b pulses=%0d exp 0/0/0",
               bit_cnt, bus.joy_data, n_done - d0);
    end
    bus.joy_load = 1'b1;
    cyc(6);
    rd_bits(32, w);
    checks++;
    if (w[31:0] !== 32'h7FFE_FFFC || n_done - d0 != 1) begin
      errors++;
      $display("FAIL abort_frame: got %h pulses=%0d exp 7ffefffc/1",
               w[31:0], n_done - d0);
    end
  endtask

  task automatic test_watchdog();
    j1 = 16'h0001;
    j2 = 16'h0000;
    do_load();
    cyc(880);
    checks++;
    if (link_active !== 1'b1) begin
      errors++;
      $display("FAIL wd_early: link=%b exp 1", link_active);
    end
    cyc(200);
    checks++;
    if (link_active !== 1'b0 || bus.joy_data !== 1'b1) begin
      errors++;
      $display("FAIL wd_expire: link=%b data=%b exp 0/1",
               link_active, bus.joy_data);
    end
    bus.joy_load = 1'b0;
    cyc(4);
    checks++;
    if (link_active !== 1'b1) begin
      errors++;
      $display("FAIL wd_relink: link=%b exp 1", link_active);
    end
    cyc(2);
    bus.joy_load = 1'b1;
    cyc(6);
  endtask

  task automatic test_loopback();
    logic [31:0] tv [16];
    logic [63:0] w;
    tv = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h1357_9BDF,
           32'h8000_0001, 32'hDEAD_BEEF, 32'h0F0F_F0F0,
           32'h5555_AAAA, 32'h2468_ACE0, 32'hC001_D00D,
           32'h7FFF_8000, 32'h0123_4567, 32'hFEDC_BA98,
           32'h3333_CCCC, 32'h9E37_79B9, 32'h4000_0002,
           32'hB16B_00B5};
    for (int k = 0; k < 16; k++) begin
      j1 = tv[k][15:0];
      j2 = tv[k][31:16];
      do_load();
      rd_bits(32, w);
      checks++;
      if (~w[31:0] !== tv[k]) begin
        errors++;
        $display("FAIL loop_%0d: got %h exp %h",
                 k, ~w[31:0], tv[k]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    logic [63:0] w;
    int d0;
    j1 = 16'hFFFF;
    j2 = 16'hFFFF;
    d0 = n_done;
    do_load();
    rd_bits(5, w);
    checks++;
    if (bus.joy_data !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre: data=%b exp 0", bus.joy_data);
    end
    reset_n = 1'b0;
    #2;
    checks++;
    if (bus.joy_data !== 1'b1 || bit_cnt !== 6'd0
        || link_active !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: data=%b cnt=%0d link=%b exp 1/0/0",
               bus.joy_data, bit_cnt, link_active);
    end
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    checks++;
    if (n_done != d0 || bus.joy_data !== 1'b1) begin
      errors++;
      $display("FAIL rst_after: pulses=%0d data=%b exp 0/1",
               n_done - d0, bus.joy_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_pattern();
    test_input_change();
    test_abort();
    test_watchdog();
    test_loopback();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
